// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared types and helpers for the 8-bit Wishbone classic master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  typedef enum logic [1:0] {
    WB_ST_OK  = 2'b00,
    WB_ST_ERR = 2'b01,
    WB_ST_RTY = 2'b10,
    WB_ST_TMO = 2'b11
  } wb_status_t;

  typedef enum logic [1:0] {
    MST_IDLE    = 2'b00,
    MST_ACTIVE  = 2'b01,
    MST_BACKOFF = 2'b10,
    MST_RESP    = 2'b11
  } wb_mst_state_t;

  // Counter only ever holds (limit-1), so $clog2 of the larger limit suffices.
  function automatic int wb_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_dcnt.sv
// ============================================================================
// Module   : wb_dcnt
// Purpose  : Loadable down-counter with enable and zero flag; saturates at 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_dcnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/wb_master_08.sv
// ============================================================================
// Module   : wb_master_08
// Purpose  : Single-outstanding 8-bit Wishbone classic master with ERR, bounded
//            RTY re-issue and no-response timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_08
  import wb_pkg::*;
#(
  parameter int WB_AWIDTH_g    = 16,
  parameter int WB_TIMEOUT_g   = 255,
  parameter int WB_MAX_RETRY_g = 3,
  parameter int WB_RETRY_GAP_g = 4
) (
  input  logic                   CLK_i,
  input  logic                   RST_i,
  input  logic                   CLK_EN_i,
  input  logic                   CMD_VALID_i,
  output logic                   CMD_READY_o,
  input  logic                   CMD_WE_i,
  input  logic [WB_AWIDTH_g-1:0] CMD_ADR_i,
  input  logic [7:0]             CMD_DAT_i,
  output logic                   RSP_VALID_o,
  output logic [7:0]             RSP_DAT_o,
  output logic [1:0]             RSP_STATUS_o,
  output logic [WB_AWIDTH_g-1:0] WBM_ADR_o,
  output logic [7:0]             WBM_DAT_o,
  input  logic [7:0]             WBM_DAT_i,
  output logic                   WBM_WE_o,
  output logic                   WBM_STB_o,
  output logic                   WBM_CYC_o,
  input  logic                   WBM_ACK_i,
  input  logic                   WBM_ERR_i,
  input  logic                   WBM_RTY_i
);

  localparam int CNT_W = wb_cnt_width(WB_TIMEOUT_g, WB_RETRY_GAP_g);
  localparam int RTY_W = (WB_MAX_RETRY_g < 2) ? 1 : $clog2(WB_MAX_RETRY_g + 1);

  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(WB_TIMEOUT_g - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WB_RETRY_GAP_g - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(WB_MAX_RETRY_g);

  wb_mst_state_t          state_q, state_d;
  logic [RTY_W-1:0]       retry_q, retry_d;
  logic                   we_q, we_d;
  logic [WB_AWIDTH_g-1:0] adr_q, adr_d;
  logic [7:0]             dat_q, dat_d;
  logic                   cyc_q, cyc_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_dat_q, rsp_dat_d;
  wb_status_t             rsp_status_q, rsp_status_d;

  logic                   accept;
  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_load_val;
  logic                   cnt_dec;
  logic                   cnt_zero;

  assign CMD_READY_o = (state_q == MST_IDLE);
  assign accept      = CMD_VALID_i & CMD_READY_o & CLK_EN_i;

  // One counter serves both the ACTIVE timeout and the BACKOFF gap.
  wb_dcnt #(
    .WIDTH (CNT_W)
  ) u_dcnt (
    .clk        (CLK_i),
    .rst        (RST_i),
    .i_en       (CLK_EN_i),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q      <= MST_IDLE;
      retry_q      <= '0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      cyc_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= WB_ST_OK;
    end else if (CLK_EN_i) begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      cyc_q        <= cyc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // Termination priority inside ACTIVE is ERR > RTY > ACK > timeout.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    cnt_load     = 1'b0;
    cnt_load_val = TMO_LOAD;
    cnt_dec      = 1'b0;
    case (state_q)
      MST_IDLE: begin
        if (accept) begin
          state_d  = MST_ACTIVE;
          we_d     = CMD_WE_i;
          adr_d    = CMD_ADR_i;
          dat_d    = CMD_DAT_i;
          retry_d  = '0;
          cnt_load = 1'b1;
        end
      end
      MST_ACTIVE: begin
        if (WBM_ERR_i) begin
          state_d      = MST_RESP;
          rsp_status_d = WB_ST_ERR;
          rsp_dat_d    = 8'h00;
        end else if (WBM_RTY_i) begin
          if (retry_q == RTY_MAX) begin
            state_d      = MST_RESP;
            rsp_status_d = WB_ST_RTY;
            rsp_dat_d    = 8'h00;
          end else begin
            state_d      = MST_BACKOFF;
            retry_d      = retry_q + RTY_W'(1);
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end
        end else if (WBM_ACK_i) begin
          state_d      = MST_RESP;
          rsp_status_d = WB_ST_OK;
          rsp_dat_d    = we_q ? 8'h00 : WBM_DAT_i;
        end else if (cnt_zero) begin
          state_d      = MST_RESP;
          rsp_status_d = WB_ST_TMO;
          rsp_dat_d    = 8'h00;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MST_BACKOFF: begin
        if (cnt_zero) begin
          state_d  = MST_ACTIVE;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MST_RESP: begin
        state_d = MST_IDLE;
      end
      default: begin
        state_d = MST_IDLE;
      end
    endcase
  end

  always_comb begin
    cyc_d       = (state_d == MST_ACTIVE);
    rsp_valid_d = (state_d == MST_RESP);
  end

  assign WBM_CYC_o    = cyc_q;
  assign WBM_STB_o    = cyc_q;
  assign WBM_WE_o     = we_q;
  assign WBM_ADR_o    = adr_q;
  assign WBM_DAT_o    = dat_q;
  assign RSP_VALID_o  = rsp_valid_q;
  assign RSP_DAT_o    = rsp_dat_q;
  assign RSP_STATUS_o = rsp_status_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_08.sv
// ============================================================================
// Module   : tb_wb_master_08
// Purpose  : Directed self-checking bench for wb_master_08 with a scripted slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_master_08;

  localparam int AW  = 16;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [7:0]    cmd_dat;
  logic          rsp_valid;
  logic [7:0]    rsp_dat;
  logic [1:0]    rsp_status;
  logic [AW-1:0] wbm_adr;
  logic [7:0]    wbm_dat_o;
  logic [7:0]    wbm_dat_i;
  logic          wbm_we;
  logic          wbm_stb;
  logic          wbm_cyc;
  logic          wbm_ack;
  logic          wbm_err;
  logic          wbm_rty;

  int            vectors     = 0;
  int            miscompares = 0;

  int            r_got, r_lat, r_stb, r_bursts, r_gap_bad, r_bus_bad, r_freeze_bad;
  logic [7:0]    r_dat;
  logic [1:0]    r_st;

  always #5 clk = ~clk;

  wb_master_08 #(
    .WB_AWIDTH_g    (AW),
    .WB_TIMEOUT_g   (8),
    .WB_MAX_RETRY_g (3),
    .WB_RETRY_GAP_g (GAP)
  ) dut (
    .CLK_i        (clk),
    .RST_i        (rst),
    .CLK_EN_i     (clk_en),
    .CMD_VALID_i  (cmd_valid),
    .CMD_READY_o  (cmd_ready),
    .CMD_WE_i     (cmd_we),
    .CMD_ADR_i    (cmd_adr),
    .CMD_DAT_i    (cmd_dat),
    .RSP_VALID_o  (rsp_valid),
    .RSP_DAT_o    (rsp_dat),
    .RSP_STATUS_o (rsp_status),
    .WBM_ADR_o    (wbm_adr),
    .WBM_DAT_o    (wbm_dat_o),
    .WBM_DAT_i    (wbm_dat_i),
    .WBM_WE_o     (wbm_we),
    .WBM_STB_o    (wbm_stb),
    .WBM_CYC_o    (wbm_cyc),
    .WBM_ACK_i    (wbm_ack),
    .WBM_ERR_i    (wbm_err),
    .WBM_RTY_i    (wbm_rty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [38:0] snapshot();
    return {wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat_o,
            rsp_valid, rsp_dat, rsp_status, cmd_ready};
  endfunction

  // mode: 0 = ACK after 'waits' enabled cycles, 1 = RTY always,
  //       2 = never respond, 3 = ACK+ERR+RTY together
  task automatic run(input logic we, input logic [AW-1:0] adr, input logic [7:0] dat,
                     input int mode, input int waits, input logic [7:0] rdat,
                     input logic toggle);
    int          wait_cnt = 0;
    int          gap_cnt  = 0;
    logic        prev_stb = 1'b0;
    logic        en;
    logic [38:0] snap;
    r_got = 0; r_lat = 0; r_stb = 0; r_bursts = 0;
    r_gap_bad = 0; r_bus_bad = 0; r_freeze_bad = 0;
    r_dat = 8'hXX; r_st = 2'bXX;
    check("ready_pre", {31'b0, cmd_ready}, 1);
    clk_en    = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    wbm_dat_i = rdat;
    tick();
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        r_got = 1;
        r_lat = i + 1;
        r_dat = rsp_dat;
        r_st  = rsp_status;
        break;
      end
      en     = toggle ? ((i % 2) == 1) : 1'b1;
      clk_en = en;
      if (wbm_cyc !== wbm_stb) r_bus_bad++;
      if (wbm_stb) begin
        if (!prev_stb) begin
          r_bursts++;
          if (r_bursts > 1 && gap_cnt != GAP) r_gap_bad++;
          wait_cnt = 0;
        end
        if (wbm_adr !== adr || wbm_we !== we || (we && wbm_dat_o !== dat)) r_bus_bad++;
        wbm_ack = (mode == 0 && wait_cnt == waits) || mode == 3;
        wbm_rty = (mode == 1) || (mode == 3);
        wbm_err = (mode == 3);
        if (en) begin
          wait_cnt++;
          r_stb++;
        end
        gap_cnt = 0;
      end else begin
        wbm_ack = 1'b0;
        wbm_rty = 1'b0;
        wbm_err = 1'b0;
        if (r_bursts > 0) gap_cnt++;
      end
      prev_stb = wbm_stb;
      snap     = snapshot();
      tick();
      if (!en && snap !== snapshot()) r_freeze_bad++;
    end
    wbm_ack = 1'b0;
    wbm_rty = 1'b0;
    wbm_err = 1'b0;
    clk_en  = 1'b1;
    check("rsp_seen", r_got, 1);
    if (r_got != 0) begin
      tick();
      check("ready_post", {31'b0, cmd_ready}, 1);
      check("rsp_one_cycle", {31'b0, rsp_valid}, 0);
    end
  endtask

  initial begin
    int n_rsp;
    rst       = 1'b1;
    clk_en    = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    wbm_dat_i = '0;
    wbm_ack   = 1'b0;
    wbm_err   = 1'b0;
    wbm_rty   = 1'b0;
    tick();
    tick();
    check("rst_cyc", {31'b0, wbm_cyc}, 0);
    check("rst_stb", {31'b0, wbm_stb}, 0);
    check("rst_we", {31'b0, wbm_we}, 0);
    check("rst_adr", {16'b0, wbm_adr}, 0);
    check("rst_dat", {24'b0, wbm_dat_o}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rsp_dat", {24'b0, rsp_dat}, 0);
    check("rst_rsp_status", {30'b0, rsp_status}, 0);
    check("rst_ready", {31'b0, cmd_ready}, 1);
    rst = 1'b0;
    tick();

    // zero-wait read
    run(1'b0, 16'h0012, 8'h00, 0, 0, 8'hA5, 1'b0);
    check("rd_dat", {24'b0, r_dat}, 32'hA5);
    check("rd_st", {30'b0, r_st}, 0);
    check("rd_stb", r_stb, 1);
    check("rd_lat", r_lat, 2);
    check("rd_bus", r_bus_bad, 0);

    // write, ACK after 3 wait states
    run(1'b1, 16'h0031, 8'h3C, 0, 3, 8'hEE, 1'b0);
    check("wr_dat", {24'b0, r_dat}, 0);
    check("wr_st", {30'b0, r_st}, 0);
    check("wr_stb", r_stb, 4);
    check("wr_bus", r_bus_bad, 0);

    // RTY on every attempt exhausts the retries
    run(1'b0, 16'h0040, 8'h00, 1, 0, 8'h77, 1'b0);
    check("rty_st", {30'b0, r_st}, 2);
    check("rty_bursts", r_bursts, 4);
    check("rty_stb", r_stb, 4);
    check("rty_gap", r_gap_bad, 0);
    check("rty_dat", {24'b0, r_dat}, 0);
    check("rty_bus", r_bus_bad, 0);

    // silent slave times out
    run(1'b0, 16'h0050, 8'h00, 2, 0, 8'h66, 1'b0);
    check("tmo_st", {30'b0, r_st}, 3);
    check("tmo_stb", r_stb, 8);
    check("tmo_dat", {24'b0, r_dat}, 0);

    // simultaneous ACK/ERR/RTY: ERR wins, no retry
    run(1'b1, 16'h0060, 8'h81, 3, 0, 8'h55, 1'b0);
    check("all_st", {30'b0, r_st}, 1);
    check("all_bursts", r_bursts, 1);
    check("all_dat", {24'b0, r_dat}, 0);

    // reset while ACTIVE drops the command
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 16'h0070;
    tick();
    cmd_valid = 1'b0;
    check("mid_stb_up", {31'b0, wbm_stb}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_cyc", {31'b0, wbm_cyc}, 0);
    check("mid_stb", {31'b0, wbm_stb}, 0);
    check("mid_rsp", {31'b0, rsp_valid}, 0);
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) n_rsp++;
    end
    check("mid_no_rsp", n_rsp, 0);
    check("mid_ready", {31'b0, cmd_ready}, 1);

    // clock enable toggling across a one-wait read
    run(1'b0, 16'h0044, 8'h00, 0, 1, 8'h5A, 1'b1);
    check("cen_dat", {24'b0, r_dat}, 32'h5A);
    check("cen_st", {30'b0, r_st}, 0);
    check("cen_stb", r_stb, 2);
    check("cen_freeze", r_freeze_bad, 0);
    check("cen_bus", r_bus_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
